// File: rtl/aes_tiled_serial_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_tiled_serial_if
//  Purpose  : Request/response bundle between the core execute stage and the
//             serial tiled AES unit.
//  Signals  : valid/flush/dec/op_sb/op_sbsr/op_mix/hi/rs1/rs2 (core -> unit),
//             ready/busy/rd (unit -> core).
//  Revision : 1.0 - initial release
// ============================================================================
interface aes_tiled_serial_if;
  logic        valid;
  logic        flush;
  logic        dec;
  logic        op_sb;
  logic        op_sbsr;
  logic        op_mix;
  logic        hi;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        ready;
  logic        busy;
  logic [31:0] rd;

  modport master (
    output valid, flush, dec, op_sb, op_sbsr, op_mix, hi, rs1, rs2,
    input  ready, busy, rd
  );

  modport slave (
    input  valid, flush, dec, op_sb, op_sbsr, op_mix, hi, rs1, rs2,
    output ready, busy, rd
  );
endinterface
`default_nettype wire

// File: rtl/aes_tiled_serial.sv
`default_nettype none
// ============================================================================
//  Module   : aes_tiled_serial
//  Purpose  : Multi-cycle AES instruction unit (SubBytes, SubBytes+ShiftRows
//             half, MixColumns and inverses) with a configurable number of
//             S-box and mix-column lanes; each result is assembled over
//             4/L steps.
//  Ports    : g_clk   - clock, rising edge
//             g_reset - synchronous active-high reset
//             bus     - aes_tiled_serial_if.slave request/response bundle
//  Revision : 1.0 - initial release
// ============================================================================
module aes_tiled_serial #(
  parameter int SBOX_LANES = 4,
  parameter int MIX_LANES  = 4,
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic              g_clk,
  input  logic              g_reset,
  aes_tiled_serial_if.slave bus
);

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_sbox_lanes
    $error("aes_tiled_serial: SBOX_LANES must be 1, 2 or 4");
  end
  if (!(MIX_LANES == 1 || MIX_LANES == 2 || MIX_LANES == 4)) begin : g_bad_mix_lanes
    $error("aes_tiled_serial: MIX_LANES must be 1, 2 or 4");
  end

  localparam int         NSB     = 4 / SBOX_LANES;
  localparam int         NMX     = 4 / MIX_LANES;
  localparam logic [1:0] LAST_SB = 2'(NSB - 1);
  localparam logic [1:0] LAST_MX = 2'(NMX - 1);
  localparam int         SH_SB   = (SBOX_LANES == 4) ? 2 : (SBOX_LANES == 2) ? 1 : 0;
  localparam int         SH_MX   = (MIX_LANES  == 4) ? 2 : (MIX_LANES  == 2) ? 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers. S-boxes are computed as inversion + affine map so that
  // forward and inverse share the same inverter structure.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // a^254 = product of a^2, a^4 ... a^128; maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] r;
    y = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] t;
    t = gf_inv(x);
    return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]}
             ^ {t[3:0], t[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // One output byte of a (inverse) MixColumns column; byte 0 is the row
  // being produced, so rotating the column selects the other rows.
  function automatic logic [7:0] mix_col_byte(input logic [31:0] c, input logic d);
    logic [7:0] b0, b1, b2, b3;
    b0 = c[7:0];
    b1 = c[15:8];
    b2 = c[23:16];
    b3 = c[31:24];
    if (d) return gf_mul(b0, 8'h0E) ^ gf_mul(b1, 8'h0B) ^ gf_mul(b2, 8'h0D) ^ gf_mul(b3, 8'h09);
    else   return gf_mul(b0, 8'h02) ^ gf_mul(b1, 8'h03) ^ b2 ^ b3;
  endfunction

  // --------------------------------------------------------------------------
  // State and captured request
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [1:0]  r_step;
  logic        r_ready;
  logic        r_busy;
  logic [31:0] r_rd;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic        r_mix;
  logic        r_sb;
  logic        r_hi;
  logic        r_d;

  // SubBytes+ShiftRows is the fall-through op, so its bit needs no decode.
  logic w_unused;
  assign w_unused = bus.op_sbsr;

  // --------------------------------------------------------------------------
  // Per-result-byte source selection (all four bytes, before lane muxing)
  // --------------------------------------------------------------------------
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [7:0]  w_sb_in [4];
  logic [31:0] w_mx_in [4];
  logic [31:0] w_c0;
  logic [31:0] w_c1;

  // The hi half is the lo half with the operands swapped.
  assign w_a  = r_hi ? r_rs2 : r_rs1;
  assign w_b  = r_hi ? r_rs1 : r_rs2;
  assign w_c0 = {r_rs1[23:16], r_rs1[31:24], r_rs2[23:16], r_rs2[31:24]};
  assign w_c1 = {r_rs1[7:0],   r_rs1[15:8],  r_rs2[7:0],   r_rs2[15:8]};

  always_comb begin
    for (int k = 0; k < 4; k++) w_sb_in[k] = r_rs1[k*8 +: 8];
    if (!r_sb) begin
      if (r_d) begin
        w_sb_in[3] = w_b[15:8];
        w_sb_in[2] = w_a[23:16];
        w_sb_in[1] = w_a[31:24];
        w_sb_in[0] = w_a[7:0];
      end else begin
        w_sb_in[3] = w_a[15:8];
        w_sb_in[2] = w_a[23:16];
        w_sb_in[1] = w_b[31:24];
        w_sb_in[0] = w_a[7:0];
      end
    end
  end

  assign w_mx_in[3] = {w_c0[23:0], w_c0[31:24]};
  assign w_mx_in[2] = w_c0;
  assign w_mx_in[1] = {w_c1[23:0], w_c1[31:24]};
  assign w_mx_in[0] = w_c1;

  // --------------------------------------------------------------------------
  // Lanes: step j handles result bytes j*L .. j*L+L-1
  // --------------------------------------------------------------------------
  logic [1:0] w_sb_base;
  logic [1:0] w_mx_base;
  logic       w_use_inv;
  logic [1:0] w_sb_idx [SBOX_LANES];
  logic [7:0] w_sb_res [SBOX_LANES];
  logic [1:0] w_mx_idx [MIX_LANES];
  logic [7:0] w_mx_res [MIX_LANES];

  assign w_sb_base = r_step << SH_SB;
  assign w_mx_base = r_step << SH_MX;
  // Plain SubBytes always uses the forward box.
  assign w_use_inv = r_d & ~r_sb;

  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_sbox
    logic [7:0] w_x;
    logic [7:0] w_fwd;
    logic [7:0] w_inv;
    assign w_sb_idx[l] = w_sb_base + 2'(l);
    assign w_x         = w_sb_in[w_sb_idx[l]];
    assign w_fwd       = sbox_fwd(w_x);
    if (DECRYPT_EN) begin : g_inv
      assign w_inv = sbox_inv(w_x);
    end else begin : g_no_inv
      assign w_inv = 8'h00;
    end
    assign w_sb_res[l] = w_use_inv ? w_inv : w_fwd;
  end

  for (genvar l = 0; l < MIX_LANES; l++) begin : g_mix
    assign w_mx_idx[l] = w_mx_base + 2'(l);
    assign w_mx_res[l] = mix_col_byte(w_mx_in[w_mx_idx[l]], r_d);
  end

  // Merge this step's lane results into rd; untouched bytes hold.
  logic [31:0] w_rd_next;
  always_comb begin
    w_rd_next = r_rd;
    if (r_mix) begin
      for (int l = 0; l < MIX_LANES; l++)
        w_rd_next[{w_mx_idx[l], 3'b000} +: 8] = w_mx_res[l];
    end else begin
      for (int l = 0; l < SBOX_LANES; l++)
        w_rd_next[{w_sb_idx[l], 3'b000} +: 8] = w_sb_res[l];
    end
  end

  logic w_last;
  assign w_last = r_mix ? (r_step == LAST_MX) : (r_step == LAST_SB);

  // --------------------------------------------------------------------------
  // Control FSM; ready/busy are registered alongside the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state <= S_IDLE;
      r_step  <= 2'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_rd    <= 32'h0;
      r_rs1   <= 32'h0;
      r_rs2   <= 32'h0;
      r_mix   <= 1'b0;
      r_sb    <= 1'b0;
      r_hi    <= 1'b0;
      r_d     <= 1'b0;
    end else if (bus.flush) begin
      // Abandon without writing the current step; rd keeps its partial value.
      r_state <= S_IDLE;
      r_step  <= 2'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (bus.valid) begin
            r_rs1   <= bus.rs1;
            r_rs2   <= bus.rs2;
            r_mix   <= bus.op_mix;
            r_sb    <= bus.op_sb & ~bus.op_mix;
            r_hi    <= bus.hi;
            r_d     <= bus.dec & DECRYPT_EN;
            r_step  <= 2'd0;
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_BUSY: begin
          r_rd <= w_rd_next;
          if (w_last) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
          end else begin
            r_step  <= r_step + 2'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.rd    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_aes_tiled_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_tiled_serial
//  Purpose  : Directed self-checking bench for aes_tiled_serial across lane
//             counts 4/2/1 and DECRYPT_EN=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_tiled_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Shared operand/op inputs; per-DUT valid and flush.
  logic        dec, op_sb, op_sbsr, op_mix, hi;
  logic [31:0] rs1, rs2;
  logic        valid_v [4];
  logic        flush_v [4];
  logic        ready_v [4];
  logic        busy_v  [4];
  logic [31:0] rd_v    [4];

  aes_tiled_serial_if if0 ();
  aes_tiled_serial_if if1 ();
  aes_tiled_serial_if if2 ();
  aes_tiled_serial_if if3 ();

  assign if0.valid = valid_v[0]; assign if0.flush = flush_v[0];
  assign if1.valid = valid_v[1]; assign if1.flush = flush_v[1];
  assign if2.valid = valid_v[2]; assign if2.flush = flush_v[2];
  assign if3.valid = valid_v[3]; assign if3.flush = flush_v[3];

  assign if0.dec = dec; assign if0.op_sb = op_sb; assign if0.op_sbsr = op_sbsr;
  assign if0.op_mix = op_mix; assign if0.hi = hi; assign if0.rs1 = rs1; assign if0.rs2 = rs2;
  assign if1.dec = dec; assign if1.op_sb = op_sb; assign if1.op_sbsr = op_sbsr;
  assign if1.op_mix = op_mix; assign if1.hi = hi; assign if1.rs1 = rs1; assign if1.rs2 = rs2;
  assign if2.dec = dec; assign if2.op_sb = op_sb; assign if2.op_sbsr = op_sbsr;
  assign if2.op_mix = op_mix; assign if2.hi = hi; assign if2.rs1 = rs1; assign if2.rs2 = rs2;
  assign if3.dec = dec; assign if3.op_sb = op_sb; assign if3.op_sbsr = op_sbsr;
  assign if3.op_mix = op_mix; assign if3.hi = hi; assign if3.rs1 = rs1; assign if3.rs2 = rs2;

  assign ready_v[0] = if0.ready; assign busy_v[0] = if0.busy; assign rd_v[0] = if0.rd;
  assign ready_v[1] = if1.ready; assign busy_v[1] = if1.busy; assign rd_v[1] = if1.rd;
  assign ready_v[2] = if2.ready; assign busy_v[2] = if2.busy; assign rd_v[2] = if2.rd;
  assign ready_v[3] = if3.ready; assign busy_v[3] = if3.busy; assign rd_v[3] = if3.rd;

  aes_tiled_serial #(.SBOX_LANES(4), .MIX_LANES(4), .DECRYPT_EN(1'b1)) dut0 (
    .g_clk(clk), .g_reset(rst), .bus(if0));
  aes_tiled_serial #(.SBOX_LANES(2), .MIX_LANES(2), .DECRYPT_EN(1'b1)) dut1 (
    .g_clk(clk), .g_reset(rst), .bus(if1));
  aes_tiled_serial #(.SBOX_LANES(1), .MIX_LANES(1), .DECRYPT_EN(1'b1)) dut2 (
    .g_clk(clk), .g_reset(rst), .bus(if2));
  aes_tiled_serial #(.SBOX_LANES(4), .MIX_LANES(4), .DECRYPT_EN(1'b0)) dut3 (
    .g_clk(clk), .g_reset(rst), .bus(if3));

  task automatic set_op(input logic s_sb, input logic s_mix, input logic s_dec,
                        input logic s_hi, input logic [31:0] a, input logic [31:0] b);
    op_sb   = s_sb;
    op_mix  = s_mix;
    op_sbsr = ~s_sb & ~s_mix;
    dec     = s_dec;
    hi      = s_hi;
    rs1     = a;
    rs2     = b;
  endtask

  // Issue one request to DUT k and check latency, result, busy and the
  // single-cycle ready pulse.
  task automatic run_op(input int k, input int n, input logic [31:0] exp, input string name);
    int cyc;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    valid_v[k] = 1'b1;
    seen    = 1'b0;
    busy_ok = 1'b1;
    cyc     = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
      if (ready_v[k] === 1'b1) begin
        seen = 1'b1;
        cyc  = c;
      end
    end
    valid_v[k] = 1'b0;
    checks++;
    if (!seen || cyc != n + 1) begin
      failures++;
      $display("FAIL %s latency: got cycle %0d, expected %0d", name, cyc, n + 1);
    end
    checks++;
    if (rd_v[k] !== exp) begin
      failures++;
      $display("FAIL %s rd: got %h, expected %h", name, rd_v[k], exp);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s busy: dropped before ready, expected high", name);
    end
    @(negedge clk);
    checks++;
    if (ready_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: got ready=%b busy=%b, expected 0 0", name, ready_v[k], busy_v[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ready_v[k] !== 1'b0) begin
        failures++; $display("FAIL reset_ready[%0d]: got %b, expected 0", k, ready_v[k]);
      end
      checks++;
      if (busy_v[k] !== 1'b0) begin
        failures++; $display("FAIL reset_busy[%0d]: got %b, expected 0", k, busy_v[k]);
      end
      checks++;
      if (rd_v[k] !== 32'h0) begin
        failures++; $display("FAIL reset_rd[%0d]: got %h, expected 0", k, rd_v[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sb();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h00530053, 32'h0);
    run_op(0, 1, 32'h63ED63ED, "sb_L4");
    run_op(1, 2, 32'h63ED63ED, "sb_L2");
    run_op(2, 4, 32'h63ED63ED, "sb_L1");
    // dec has no effect on plain SubBytes
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h53000000, 32'h0);
    run_op(0, 1, 32'hED636363, "sb_dec_ignored");
  endtask

  task automatic test_sbsr();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h00000053, 32'h0);
    run_op(0, 1, 32'h636363ED, "sbsr_fwd_lo_L4");
    run_op(2, 4, 32'h636363ED, "sbsr_fwd_lo_L1");
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000053, 32'h0);
    run_op(1, 2, 32'h63636363, "sbsr_fwd_hi");
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h53000000);
    run_op(1, 2, 32'h6363ED63, "sbsr_fwd_lo_rs2b3");
    set_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h63636363, 32'h63636363);
    run_op(0, 1, 32'h00000000, "sbsr_inv_hi");
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h63636363, 32'h6363ED63);
    run_op(1, 2, 32'h53000000, "sbsr_inv_lo");
  endtask

  task automatic test_mix();
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    run_op(0, 1, 32'h5A5A5A5A, "mix_fix_enc");
    set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    run_op(2, 4, 32'h5A5A5A5A, "mix_fix_dec");
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    run_op(0, 1, 32'h00000000, "mix_zero");
    // columns db,13,53,45 and f2,0a,22,5c; op_sb also set to check priority
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h5345225C, 32'hDB13F20A);
    run_op(1, 2, 32'hBC8E9D9F, "mix_enc_vec");
    set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'hA1BC589D, 32'h8E4D9FDC);
    run_op(2, 4, 32'h45DB5CF2, "mix_dec_vec");
  endtask

  task automatic test_no_decrypt();
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h00000053, 32'h0);
    run_op(3, 1, 32'h636363ED, "nodec_sbsr");
    set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h5345225C, 32'hDB13F20A);
    run_op(3, 1, 32'hBC8E9D9F, "nodec_mix");
  endtask

  task automatic test_flush();
    bit ready_seen;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000053, 32'h0);
    @(negedge clk);
    valid_v[2] = 1'b1;
    flush_v[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_v[2] !== 1'b0) begin
      failures++; $display("FAIL flush_with_valid: got busy=%b, expected 0", busy_v[2]);
    end
    flush_v[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_v[2] !== 1'b1) begin
      failures++; $display("FAIL flush_accept: got busy=%b, expected 1", busy_v[2]);
    end
    @(negedge clk);  // step 1 in progress
    flush_v[2] = 1'b1;
    valid_v[2] = 1'b0;
    @(negedge clk);
    flush_v[2] = 1'b0;
    checks++;
    if (busy_v[2] !== 1'b0 || ready_v[2] !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: got busy=%b ready=%b, expected 0 0", busy_v[2], ready_v[2]);
    end
    ready_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready_v[2] === 1'b1) ready_seen = 1'b1;
    end
    checks++;
    if (ready_seen) begin
      failures++; $display("FAIL flush_no_ready: got ready=1, expected 0");
    end
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h53530000, 32'h0);
    run_op(2, 4, 32'hEDED6363, "after_flush");
  endtask

  task automatic test_reset_mid();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h53535353, 32'h0);
    @(negedge clk);
    valid_v[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_v[1] !== 1'b1) begin
      failures++; $display("FAIL rstmid_busy: got %b, expected 1", busy_v[1]);
    end
    rst = 1'b1;
    valid_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_v[1] !== 1'b0 || ready_v[1] !== 1'b0 || rd_v[1] !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_outputs: got busy=%b ready=%b rd=%h, expected 0 0 0",
               busy_v[1], ready_v[1], rd_v[1]);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    bit seen;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000053, 32'h0);
    @(negedge clk);
    valid_v[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (ready_v[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || rd_v[0] !== 32'h636363ED) begin
      failures++; $display("FAIL b2b_first: got rd=%h, expected 636363ed", rd_v[0]);
    end
    // keep valid high with new operands: next IDLE cycle accepts them
    rs1  = 32'h53000000;
    seen = 1'b0;
    gap  = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (ready_v[0] === 1'b1) begin
        seen = 1'b1;
        gap  = c;
      end
    end
    valid_v[0] = 1'b0;
    checks++;
    if (gap != 3) begin
      failures++; $display("FAIL b2b_gap: got %0d cycles, expected 3", gap);
    end
    checks++;
    if (rd_v[0] !== 32'hED636363) begin
      failures++; $display("FAIL b2b_second: got rd=%h, expected ed636363", rd_v[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      valid_v[k] = 1'b0;
      flush_v[k] = 1'b0;
    end
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_sb();
    test_sbsr();
    test_mix();
    test_no_decrypt();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
